// File: rtl/prefetch_queue_if.sv
// Decoder/memory-side bundle of the instruction prefetch queue.
// The slave modport is the queue itself; master is the surrounding fetch/decode logic.
interface prefetch_queue_if #(
    parameter int DATA_BITS = 16,
    parameter int IN_BITS   = 8,
    parameter int DEPTH     = 3
);
    logic                           flush;
    logic                           in_valid;
    logic [IN_BITS-1:0]             in_data;
    logic                           in_ready;
    logic [1:0]                     pop;
    logic                           out_valid0;
    logic [DATA_BITS-1:0]           out_data0;
    logic                           out_valid1;
    logic [DATA_BITS-1:0]           out_data1;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport master (
        output flush, in_valid, in_data, pop,
        input  in_ready, out_valid0, out_data0, out_valid1, out_data1, count
    );

    modport slave (
        input  flush, in_valid, in_data, pop,
        output in_ready, out_valid0, out_data0, out_valid1, out_data1, count
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: assembles little-endian beats into words and holds DEPTH
// of them in a shift-down array whose entry 0 is always the oldest word.
module prefetch_queue #(
    parameter int DATA_BITS = 16,
    parameter int IN_BITS   = 8,
    parameter int DEPTH     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    prefetch_queue_if.slave     bus
);
    localparam int CHUNKS = DATA_BITS / IN_BITS;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CNTW   = $clog2(DEPTH + 1);

    logic [DATA_BITS-1:0] data_q  [DEPTH];
    logic [DATA_BITS-1:0] data_d  [DEPTH];
    logic [DATA_BITS-1:0] shift_w [DEPTH];
    logic [CNTW-1:0]      count_q, count_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic [DATA_BITS-1:0] word_w;
    logic [CNTW-1:0]      popped_w;
    logic [CNTW-1:0]      wr_idx_w;
    logic                 in_ready_w;
    logic                 accept_w;
    logic                 last_w;
    logic                 push_w;

    assign in_ready_w = (count_q < CNTW'(DEPTH));
    // Flush swallows a beat presented in the same cycle, even with room available.
    assign accept_w   = bus.in_valid && in_ready_w && !bus.flush;
    assign last_w     = (chunk_q == CW'(CHUNKS - 1));
    assign push_w     = accept_w && last_w;

    assign bus.in_ready   = in_ready_w;
    assign bus.count      = count_q;
    assign bus.out_valid0 = (count_q >= CNTW'(1));
    assign bus.out_valid1 = (count_q >= CNTW'(2));
    assign bus.out_data0  = data_q[0];
    assign bus.out_data1  = data_q[1];

    always_comb begin
        logic [CNTW-1:0] req;
        req = '0;
        if (!bus.flush) begin
            case (bus.pop)
                2'd0:    req = CNTW'(0);
                2'd1:    req = CNTW'(1);
                default: req = CNTW'(2);
            endcase
        end
        popped_w = (req > count_q) ? count_q : req;
    end

    assign wr_idx_w = count_q - popped_w;

    generate
        if (CHUNKS > 1) begin : g_asm
            logic [DATA_BITS-1:0] asm_q;
            for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
                // The incoming beat completes the word without waiting for asm_q.
                assign word_w[gi*IN_BITS +: IN_BITS] =
                    (chunk_q == CW'(gi)) ? bus.in_data : asm_q[gi*IN_BITS +: IN_BITS];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        asm_q[gi*IN_BITS +: IN_BITS] <= '0;
                    end else if (accept_w && chunk_q == CW'(gi)) begin
                        asm_q[gi*IN_BITS +: IN_BITS] <= bus.in_data;
                    end
                end
            end
        end else begin : g_direct
            assign word_w = bus.in_data;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi + 2 < DEPTH) begin : g_shift2
                assign shift_w[gi] = (popped_w == CNTW'(2)) ? data_q[gi+2] :
                                     (popped_w == CNTW'(1)) ? data_q[gi+1] : data_q[gi];
            end else if (gi + 1 < DEPTH) begin : g_shift1
                assign shift_w[gi] = (popped_w != CNTW'(0)) ? data_q[gi+1] : data_q[gi];
            end else begin : g_hold
                assign shift_w[gi] = data_q[gi];
            end
            assign data_d[gi] = (push_w && wr_idx_w == CNTW'(gi)) ? word_w : shift_w[gi];
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        chunk_d = chunk_q;
        if (bus.flush) begin
            count_d = '0;
            chunk_d = '0;
        end else begin
            count_d = count_q - popped_w + CNTW'(push_w);
            if (accept_w) begin
                chunk_d = last_w ? '0 : chunk_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            chunk_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            chunk_q <= chunk_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: an 8-bit-beat instance and a 16-bit-beat instance.
module tb_prefetch_queue;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    prefetch_queue_if #(.DATA_BITS(16), .IN_BITS(8),  .DEPTH(3)) a_if ();
    prefetch_queue_if #(.DATA_BITS(16), .IN_BITS(16), .DEPTH(3)) b_if ();

    prefetch_queue #(.DATA_BITS(16), .IN_BITS(8), .DEPTH(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    prefetch_queue #(.DATA_BITS(16), .IN_BITS(16), .DEPTH(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        step();
        a_if.in_valid = 1'b0;
    endtask

    task automatic show(input string tag);
        $display("%s: count=%0d in_ready=%0b v0=%0b d0=%04h v1=%0b d1=%04h", tag,
                 a_if.count, a_if.in_ready, a_if.out_valid0, a_if.out_data0,
                 a_if.out_valid1, a_if.out_data1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        a_if.flush = 1'b0; a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.pop = 2'd0;
        b_if.flush = 1'b0; b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.pop = 2'd0;
        #12;
        show("reset");
        check("rst_count",    32'(a_if.count),      32'd0);
        check("rst_in_ready", 32'(a_if.in_ready),   32'd1);
        check("rst_valid0",   32'(a_if.out_valid0), 32'd0);
        check("rst_valid1",   32'(a_if.out_valid1), 32'd0);
        check("rst_data0",    32'(a_if.out_data0),  32'h0000);
        check("rst_b_count",  32'(b_if.count),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Two words assembled little-endian
        beat(8'h34);
        beat(8'h12);
        show("word1");
        check("asm_count1", 32'(a_if.count),     32'd1);
        check("asm_data0",  32'(a_if.out_data0), 32'h1234);
        beat(8'h78);
        beat(8'h56);
        show("word2");
        check("asm_count2", 32'(a_if.count),      32'd2);
        check("asm_data1",  32'(a_if.out_data1),  32'h5678);
        check("asm_valid1", 32'(a_if.out_valid1), 32'd1);

        // Fill to full, hold a beat, release with pop=1
        a_if.pop = 2'd2;
        step();
        a_if.pop = 2'd0;
        check("drain_count", 32'(a_if.count), 32'd0);
        for (int i = 1; i <= 6; i++) beat(8'(i));
        show("full");
        check("full_count",    32'(a_if.count),     32'd3);
        check("full_in_ready", 32'(a_if.in_ready),  32'd0);
        check("full_data0",    32'(a_if.out_data0), 32'h0201);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'h07;
        step();
        check("held_count", 32'(a_if.count), 32'd3);
        a_if.pop = 2'd1;
        step();
        a_if.pop = 2'd0;
        show("pop_full");
        check("popf_count",    32'(a_if.count),     32'd2);
        check("popf_in_ready", 32'(a_if.in_ready),  32'd1);
        check("popf_data0",    32'(a_if.out_data0), 32'h0403);
        check("popf_data1",    32'(a_if.out_data1), 32'h0605);
        step();
        a_if.in_valid = 1'b0;
        beat(8'h08);
        check("held_acc_count", 32'(a_if.count), 32'd3);
        a_if.pop = 2'd2;
        step();
        a_if.pop = 2'd0;
        check("held_acc_data0", 32'(a_if.out_data0), 32'h0807);

        // Flush, then push during pop=2
        a_if.flush = 1'b1;
        step();
        a_if.flush = 1'b0;
        check("flush1_count", 32'(a_if.count), 32'd0);
        beat(8'h34); beat(8'h12); beat(8'h78); beat(8'h56);
        beat(8'hEF);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'hBE;
        a_if.pop      = 2'd2;
        step();
        a_if.in_valid = 1'b0;
        a_if.pop      = 2'd0;
        show("push_pop2");
        check("pp2_count",  32'(a_if.count),      32'd1);
        check("pp2_data0",  32'(a_if.out_data0),  32'hBEEF);
        check("pp2_valid1", 32'(a_if.out_valid1), 32'd0);

        // Flush discards both the partial word and the same-cycle beat
        beat(8'hAA);
        a_if.flush    = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'hCC;
        a_if.pop      = 2'd1;
        step();
        a_if.flush    = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.pop      = 2'd0;
        show("flush");
        check("fl_count",    32'(a_if.count),      32'd0);
        check("fl_valid0",   32'(a_if.out_valid0), 32'd0);
        check("fl_in_ready", 32'(a_if.in_ready),   32'd1);
        beat(8'h11);
        beat(8'h22);
        check("fl_after_count", 32'(a_if.count),     32'd1);
        check("fl_after_data0", 32'(a_if.out_data0), 32'h2211);

        // Over-pop never underflows
        a_if.pop = 2'd2;
        step();
        a_if.pop = 2'd0;
        check("pop2_c1_count", 32'(a_if.count), 32'd0);
        beat(8'hB2); beat(8'hA1); beat(8'hD4); beat(8'hC3);
        check("pre_pop3_count", 32'(a_if.count), 32'd2);
        a_if.pop = 2'd3;
        step();
        a_if.pop = 2'd0;
        check("pop3_count", 32'(a_if.count), 32'd0);

        // Push with pop=1 at count=2 lands in entry 1
        beat(8'hB2); beat(8'hA1); beat(8'hD4); beat(8'hC3);
        beat(8'hF6);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'hE5;
        a_if.pop      = 2'd1;
        step();
        a_if.in_valid = 1'b0;
        a_if.pop      = 2'd0;
        show("push_pop1");
        check("pp1_count", 32'(a_if.count),     32'd2);
        check("pp1_data0", 32'(a_if.out_data0), 32'hC3D4);
        check("pp1_data1", 32'(a_if.out_data1), 32'hE5F6);

        // Reset mid-assembly loses the partial word
        a_if.flush = 1'b1;
        step();
        a_if.flush = 1'b0;
        beat(8'h99);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_count", 32'(a_if.count),     32'd0);
        check("amid_data0", 32'(a_if.out_data0), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        beat(8'h11);
        beat(8'h22);
        check("amid_after_data0", 32'(a_if.out_data0), 32'h2211);

        // 16-bit beats: one beat per word
        b_if.in_valid = 1'b1;
        b_if.in_data  = 16'hABCD;
        step();
        check("b_count1", 32'(b_if.count),     32'd1);
        check("b_data0",  32'(b_if.out_data0), 32'hABCD);
        b_if.in_data  = 16'h1357;
        step();
        b_if.in_valid = 1'b0;
        $display("b: count=%0d d0=%04h d1=%04h", b_if.count, b_if.out_data0, b_if.out_data1);
        check("b_count2", 32'(b_if.count),     32'd2);
        check("b_data0b", 32'(b_if.out_data0), 32'hABCD);
        check("b_data1",  32'(b_if.out_data1), 32'h1357);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Parametrised successor to the CPU's fixed 3-entry, 16-bit instruction prefetch FIFO.
- Assembles IN_BITS-wide memory beats, little-endian, into DATA_BITS-wide instruction words and buffers DEPTH of them.
- Exposes the two oldest words at once, so the decoder can take one- or two-word instructions in a single cycle.
- Adds a flush for taken jumps that discards queued words and any partially assembled word.

Parameters:
DATA_BITS, 16, instruction word width
IN_BITS, 8, input beat width; DATA_BITS must be an integer multiple of IN_BITS (CHUNKS = DATA_BITS/IN_BITS >= 1)
DEPTH, 3, number of word entries; must be >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all queued and partial data this cycle
in_valid  input  1  beat present on in_data
in_data  input  IN_BITS  memory beat
in_ready  output  1  beat is accepted when in_valid && in_ready
pop  input  2  number of words consumed this cycle (0, 1, 2; 3 treated as 2)
out_valid0  output  1  head word valid (count >= 1)
out_data0  output  DATA_BITS  head word, data[0]
out_valid1  output  1  second word valid (count >= 2)
out_data1  output  DATA_BITS  second word, data[1]
count  output  $clog2(DEPTH+1)  number of complete words held

Behaviour:
- Reset (async, rst_n low): count=0, chunk index=0, all data[] and the assembly register=0. Therefore in_ready=1, out_valid0/1=0, out_data0/1=0.
- Storage organisation: shift-down queue. data[0] is always the head; data[1..DEPTH-1] follow in age order. Debug probes rely on this.
- Clocking: all state updates on the rising clk edge. Outputs come combinationally from registers only; no input-to-output combinational paths except none.
- in_ready:
  - in_ready = (count < DEPTH), computed from the registered count.
  - Partial beats are also blocked when the queue is full.
- Assembly:
  - Beat k (k = 0..CHUNKS-1) of a word fills bits [k*IN_BITS +: IN_BITS].
  - The chunk index increments per accepted beat and wraps to 0 after beat CHUNKS-1.
  - When CHUNKS=1, every accepted beat is a complete word and there is no assembly register.
- Push:
  - Accepting the final beat of a word pushes the complete word.
  - The word is visible on out_data*/count the cycle after acceptance (latency 1).
- Pop:
  - popped = min(pop clamped to 2, count). Popping more than count never underflows.
  - Remaining entries shift down by popped.
  - Vacated entries retain their old values; they are don't-care and must not be checked.
- Simultaneous push and pop in one cycle:
  - count_next = count - popped + pushed.
  - The new word is written at index count - popped.
- Full queue: push is impossible while count=DEPTH because in_ready=0. A pop while full raises in_ready on the next cycle, not combinationally.
- Flush:
  - Highest priority.
  - count <= 0 and chunk index <= 0.
  - A beat presented the same cycle is discarded even if in_ready=1.
  - pop is ignored that cycle.
  - The next cycle: out_valid0/1=0, in_ready=1.
- Reset mid-assembly: the partial word is lost and the chunk index returns to 0.
- out_data1 while out_valid1=0: undefined, but must equal data[1] register contents.

Test Plan:
1. Reset (defaults, IN_BITS=8) -> count=0, in_ready=1, out_valid0=0, out_valid1=0, out_data0=0x0000.
2. Beats 0x34,0x12,0x78,0x56, no pop -> one cycle after 2nd beat: count=1, out_data0=0x1234. One cycle after 4th beat: count=2, out_data1=0x5678, out_valid1=1.
3. Push 6 beats (0x01..0x06) to reach count=3 -> in_ready=0 and a 7th beat is held (not accepted). Then pop=1 -> next cycle count=2, in_ready=1, out_data0=0x0403. The held beat is accepted afterwards.
4. count=2 (0x1234, 0x5678); final beat of 0xBEEF accepted in the same cycle as pop=2 -> next cycle count=1, out_data0=0xBEEF, out_valid1=0.
5. Accept 0xAA, then flush with in_valid=1/in_data=0xCC, then 0x11,0x22 -> after flush count=0. Result is out_data0=0x2211; both 0xAA and 0xCC are discarded.
6. count=1, pop=2 -> count=0, no underflow. Then count=2, pop=3 -> count=0. IN_BITS=16 build: each accepted beat gives count+1 the next cycle with out_data0=in_data.
